fa_call_dispatcher: RTL and testbench
=====================================

FA_CALL_DISPATCHER -- requirements
Module: fa_call_dispatcher

Interface
REQ-001 SHALL have parameter N_SEATS, default 8, number of seat call stations (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, dispatch-acknowledge timeout used only under FA_CALL_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port call_button  input  N_SEATS  per-seat call request, level, synchronous to clk.
REQ-006 SHALL have port cancel_button  input  N_SEATS  per-seat cancel request, level.
REQ-007 SHALL have port attendant_ack  input  1  attendant accepts the offered dispatch.
REQ-008 SHALL have port attendant_done  input  1  attendant finished serving the current seat.
REQ-009 SHALL have port light_state  output  N_SEATS  registered per-seat call light.
REQ-010 SHALL have port dispatch_valid  output  1  registered; a seat is offered to the attendant.
REQ-011 SHALL have port dispatch_seat  output  4  registered index of the offered/served seat.
REQ-012 SHALL have port busy  output  1  registered; high in SERVING.
REQ-013 SHALL have port escalate  output  1  registered timeout flag.

Function
REQ-014 SHALL set light_state[i] one cycle after call_button[i]=1; SHALL clear it one cycle after cancel_button[i]=1 with call_button[i]=0; call dominates when both are high.
REQ-015 SHALL implement FSM states IDLE, DISPATCH, SERVING.
REQ-016 IDLE: if any light_state bit set, SHALL select a seat round-robin, load dispatch_seat, enter DISPATCH with dispatch_valid=1 next cycle.
REQ-017 Round-robin SHALL search upward from (last_served+1) mod N_SEATS, wrapping; last_served resets to N_SEATS-1 so seat 0 has first priority.
REQ-018 DISPATCH: dispatch_valid and dispatch_seat SHALL hold stable until attendant_ack or cancel of the offered seat.
REQ-019 DISPATCH + attendant_ack=1 SHALL enter SERVING next cycle: dispatch_valid=0, busy=1, last_served=dispatch_seat.
REQ-020 DISPATCH + offered seat's light cleared by cancel (same cycle as ack: ack wins) SHALL return to IDLE without updating last_served.
REQ-021 SERVING: the served seat's light SHALL stay set, ignoring cancel; other seats' lights update normally.
REQ-022 SERVING + attendant_done=1 SHALL clear the served seat's light and return to IDLE next cycle, busy=0; call_button on that seat in the same cycle SHALL re-set the light.
REQ-023 attendant_ack outside DISPATCH and attendant_done outside SERVING SHALL be ignored.
REQ-024 Back-to-back: IDLE->DISPATCH minimum spacing SHALL be one IDLE cycle after SERVING.
REQ-025 dispatch_seat SHALL hold its last value in IDLE; indices above N_SEATS-1 never produced.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, light_state=0, dispatch_valid=0, dispatch_seat=0, busy=0, escalate=0, timeout counter=0, last_served=N_SEATS-1.
REQ-027 Reset mid-DISPATCH or mid-SERVING SHALL abandon the transaction; first dispatch after release no earlier than two cycles after rst_n rises.

Configuration
REQ-028 With FA_CALL_TIMEOUT_EN defined: counter SHALL count DISPATCH cycles; reaching TIMEOUT_CYCLES without ack SHALL set escalate=1 (held until ack, cancel of offered seat, or reset); counter clears on leaving DISPATCH.
REQ-029 Without FA_CALL_TIMEOUT_EN: no counter logic; escalate SHALL be constant 0.

Verification
REQ-030 Reset, call_button=8'h04 one cycle -> light_state=8'h04, next cycle dispatch_valid=1, dispatch_seat=2.
REQ-031 Lights 8'h81 pending, last_served=0 -> dispatch seat 7 first, then after done seat 0 (wrap).
REQ-032 DISPATCH seat 3, cancel_button[3]=1 -> light[3]=0, IDLE, dispatch_valid=0; same cycle with attendant_ack -> SERVING seat 3.
REQ-033 SERVING seat 5, cancel_button[5]=1 -> light[5] stays 1; attendant_done -> light[5]=0, busy=0 next cycle.
REQ-034 call and cancel same seat same cycle -> light set; rst_n low mid-SERVING -> all outputs 0 asynchronously.
REQ-035 FA_CALL_TIMEOUT_EN, TIMEOUT_CYCLES=10, no ack -> escalate=1 after 10 DISPATCH cycles; ack -> escalate=0; macro undefined -> escalate always 0.

Source files
------------

// File: rtl/fa_call_dispatcher.sv
// Seat call lights with round-robin attendant dispatch (IDLE -> DISPATCH -> SERVING).
// Define FA_CALL_TIMEOUT_EN to build the dispatch-acknowledge timeout that drives escalate.
module fa_call_dispatcher #(
  parameter int N_SEATS        = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SEATS-1:0] call_button,
  input  logic [N_SEATS-1:0] cancel_button,
  input  logic               attendant_ack,
  input  logic               attendant_done,
  output logic [N_SEATS-1:0] light_state,
  output logic               dispatch_valid,
  output logic [3:0]         dispatch_seat,
  output logic               busy,
  output logic               escalate
);

  typedef enum logic [1:0] {IDLE, DISPATCH, SERVING} state_t;

  localparam logic [N_SEATS-1:0] ONE = {{(N_SEATS-1){1'b0}}, 1'b1};

  if (N_SEATS < 2 || N_SEATS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fa_call_dispatcher: N_SEATS must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  state_t             r_state;
  logic [N_SEATS-1:0] r_light;
  logic               r_valid;
  logic [3:0]         r_seat;
  logic               r_busy;
  logic [3:0]         r_last;

  logic [N_SEATS-1:0] w_seat_mask;
  logic [N_SEATS-1:0] w_light_base;
  logic [N_SEATS-1:0] w_light_next;
  logic               w_offer_drop;
  logic               w_found;
  logic [3:0]         w_pick;
  logic [4:0]         w_idx;

  // Plain per-seat rule: call sets, cancel clears, call wins a tie.
  assign w_seat_mask  = ONE << r_seat;
  assign w_light_base = call_button | (r_light & ~cancel_button);
  assign w_offer_drop = !attendant_ack && ((w_light_base & w_seat_mask) == '0);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_light_next = w_light_base;
    case (r_state)
      DISPATCH: if (attendant_ack) w_light_next = w_light_base | w_seat_mask;
      SERVING: begin
        if (attendant_done)
          w_light_next = (w_light_base & ~w_seat_mask) | (call_button & w_seat_mask);
        else
          w_light_next = w_light_base | w_seat_mask;
      end
      default: ;
    endcase
  end

  // NOTE: blocking assignments here are intentional; w_idx is a loop-local scratch value.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < N_SEATS; k++) begin
      w_idx = 5'(r_last) + 5'd1 + 5'(k);
      if (w_idx >= 5'(N_SEATS)) w_idx = w_idx - 5'(N_SEATS);
      if (!w_found && (((r_light >> w_idx) & ONE) != '0)) begin
        w_found = 1'b1;
        w_pick  = w_idx[3:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_light <= '0;
      r_valid <= 1'b0;
      r_seat  <= '0;
      r_busy  <= 1'b0;
      r_last  <= 4'(N_SEATS - 1);
    end else begin
      r_light <= w_light_next;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_seat  <= w_pick;
            r_valid <= 1'b1;
            r_state <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (attendant_ack) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_last  <= r_seat;
            r_state <= SERVING;
          end else if (w_offer_drop) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        SERVING: begin
          if (attendant_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FA_CALL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;
  logic          r_escalate;

  // Counts cycles the offer stays open; saturates so escalate latches until the offer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= '0;
      r_escalate <= 1'b0;
    end else if (r_state == DISPATCH && !attendant_ack && !w_offer_drop) begin
      if (r_timer != TW'(TIMEOUT_CYCLES)) r_timer <= r_timer + 1'b1;
      if (r_timer == TW'(TIMEOUT_CYCLES - 1)) r_escalate <= 1'b1;
    end else begin
      r_timer    <= '0;
      r_escalate <= 1'b0;
    end
  end

  assign escalate = r_escalate;
`else
  assign escalate = 1'b0;
`endif

  assign light_state    = r_light;
  assign dispatch_valid = r_valid;
  assign dispatch_seat  = r_seat;
  assign busy           = r_busy;

endmodule

// File: tb/tb_fa_call_dispatcher.sv
// Bench for fa_call_dispatcher: directed scenarios plus randomized traffic checked
// every cycle against a seat-level behavioural model.
module tb_fa_call_dispatcher;

  localparam int N  = 8;
  localparam int TO = 10;
`ifdef FA_CALL_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] call_button = '0;
  logic [N-1:0] cancel_button = '0;
  logic         attendant_ack = 1'b0;
  logic         attendant_done = 1'b0;
  logic [N-1:0] light_state;
  logic         dispatch_valid;
  logic [3:0]   dispatch_seat;
  logic         busy;
  logic         escalate;

  fa_call_dispatcher #(.N_SEATS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .call_button   (call_button),
    .cancel_button (cancel_button),
    .attendant_ack (attendant_ack),
    .attendant_done(attendant_done),
    .light_state   (light_state),
    .dispatch_valid(dispatch_valid),
    .dispatch_seat (dispatch_seat),
    .busy          (busy),
    .escalate      (escalate)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit armed = 1'b0;

  // Model: one bit per seat light, whether a seat is being offered or served, and which one.
  bit m_light[N];
  bit m_offered;
  bit m_serving;
  bit m_esc;
  int m_seat;
  int m_last;
  int m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_light_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_light[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_light[i] = 1'b0;
    m_offered = 1'b0;
    m_serving = 1'b0;
    m_esc     = 1'b0;
    m_seat    = 0;
    m_last    = N - 1;
    m_wait    = 0;
  endfunction

  function automatic void m_step(input logic [N-1:0] c, input logic [N-1:0] x,
                                 input logic a, input logic d);
    bit nl[N];
    for (int i = 0; i < N; i++) nl[i] = c[i] || (m_light[i] && !x[i]);
    if (m_offered) begin
      if (a) begin
        nl[m_seat] = 1'b1;
        m_offered  = 1'b0;
        m_serving  = 1'b1;
        m_last     = m_seat;
        m_wait     = 0;
        m_esc      = 1'b0;
      end else if (!nl[m_seat]) begin
        m_offered = 1'b0;
        m_wait    = 0;
        m_esc     = 1'b0;
      end else if (TIMEOUT_ON) begin
        m_wait++;
        if (m_wait >= TO) m_esc = 1'b1;
      end
    end else if (m_serving) begin
      if (d) begin
        nl[m_seat] = c[m_seat];
        m_serving  = 1'b0;
      end else begin
        nl[m_seat] = 1'b1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (m_light[j]) begin
          m_seat    = j;
          m_offered = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) m_light[i] = nl[i];
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      check("light_state", 32'(light_state), 32'(m_light_vec()));
      check("dispatch_valid", 32'(dispatch_valid), 32'(m_offered));
      check("dispatch_seat", 32'(dispatch_seat), 32'(m_seat));
      check("busy", 32'(busy), 32'(m_serving));
      check("escalate", 32'(escalate), 32'(m_esc));
    end
  end

  task automatic drive(input logic [N-1:0] c, input logic [N-1:0] x, input logic a, input logic d);
    call_button    = c;
    cancel_button  = x;
    attendant_ack  = a;
    attendant_done = d;
    @(posedge clk);
    if (rst_n) m_step(c, x, a, d);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rc;
    logic [N-1:0] rx;

    m_reset();
    @(posedge clk);
    #2;
    armed = 1'b1;

    // First call after reset: light next cycle, offer the cycle after.
    do_reset();
    drive(8'h04, '0, 1'b0, 1'b0);
    check("t1_light", 32'(light_state), 32'h04);
    check("t1_valid_early", 32'(dispatch_valid), 32'h0);
    drive('0, '0, 1'b0, 1'b0);
    check("t1_valid", 32'(dispatch_valid), 32'h1);
    check("t1_seat", 32'(dispatch_seat), 32'h2);

    // Round-robin wrap with lights 0x81 after serving seat 0; call re-sets light on done.
    do_reset();
    drive(8'h01, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("t2_seat0", 32'(dispatch_seat), 32'h0);
    drive('0, '0, 1'b1, 1'b0);
    check("t2_busy", 32'(busy), 32'h1);
    drive(8'h81, '0, 1'b0, 1'b1);
    check("t2_light81", 32'(light_state), 32'h81);
    check("t2_idle_gap", 32'(dispatch_valid), 32'h0);
    drive('0, '0, 1'b0, 1'b0);
    check("t2_seat7", 32'(dispatch_seat), 32'h7);
    drive('0, '0, 1'b1, 1'b0);
    drive('0, '0, 1'b0, 1'b1);
    check("t2_light01", 32'(light_state), 32'h01);
    drive('0, '0, 1'b0, 1'b0);
    check("t2_wrap_seat0", 32'(dispatch_seat), 32'h0);
    check("t2_wrap_valid", 32'(dispatch_valid), 32'h1);

    // Cancel of the offered seat withdraws it; cancel together with ack is served.
    do_reset();
    drive(8'h08, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("t3_seat3", 32'(dispatch_seat), 32'h3);
    drive('0, 8'h08, 1'b0, 1'b0);
    check("t3_cancel_light", 32'(light_state[3]), 32'h0);
    check("t3_cancel_valid", 32'(dispatch_valid), 32'h0);
    drive(8'h08, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    drive('0, 8'h08, 1'b1, 1'b0);
    check("t3_ackwin_busy", 32'(busy), 32'h1);
    check("t3_ackwin_light", 32'(light_state[3]), 32'h1);
    check("t3_ackwin_valid", 32'(dispatch_valid), 32'h0);

    // Served seat ignores cancel; done clears it.
    do_reset();
    drive(8'h20, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    drive('0, 8'h20, 1'b0, 1'b0);
    check("t4_hold_light", 32'(light_state[5]), 32'h1);
    check("t4_hold_busy", 32'(busy), 32'h1);
    drive('0, '0, 1'b0, 1'b1);
    check("t4_done_light", 32'(light_state[5]), 32'h0);
    check("t4_done_busy", 32'(busy), 32'h0);

    // Call beats cancel; asynchronous reset mid-SERVING; first offer two cycles after release.
    do_reset();
    drive(8'h02, 8'h02, 1'b0, 1'b0);
    check("t5_call_wins", 32'(light_state), 32'h02);
    drive('0, '0, 1'b0, 1'b0);
    drive(8'h02, '0, 1'b1, 1'b0);
    check("t5_serving", 32'(busy), 32'h1);
    #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("t5_async_light", 32'(light_state), 32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    check("t5_async_valid", 32'(dispatch_valid), 32'h0);
    check("t5_async_seat", 32'(dispatch_seat), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(8'h02, '0, 1'b0, 1'b0);
    check("t5_rel_valid_early", 32'(dispatch_valid), 32'h0);
    drive('0, '0, 1'b0, 1'b0);
    check("t5_rel_valid", 32'(dispatch_valid), 32'h1);
    check("t5_rel_seat", 32'(dispatch_seat), 32'h1);

    // Unacknowledged offer: escalate exactly TO cycles into DISPATCH (when built in).
    do_reset();
    drive(8'h01, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    repeat (TO - 1) drive('0, '0, 1'b0, 1'b0);
    check("t6_esc_before", 32'(escalate), 32'h0);
    drive('0, '0, 1'b0, 1'b0);
    check("t6_esc_at", 32'(escalate), 32'(TIMEOUT_ON));
    drive('0, '0, 1'b1, 1'b0);
    check("t6_esc_ack", 32'(escalate), 32'h0);
    check("t6_busy_ack", 32'(busy), 32'h1);

    // Randomized traffic, including stray ack/done and occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) begin
        rc[i] = ($urandom_range(0, 11) == 0);
        rx[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else drive(rc, rx, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
